// File: rtl/imem_line_responder.sv
// Instruction-fetch responder: single-line buffer that serves hits combinationally
// and refills on a miss with an Avalon-style pipelined burst. Optional flush via IMEM_FLUSH_EN.
module imem_line_responder #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef IMEM_FLUSH_EN
    input  logic                          i_flush,
`endif
    input  logic [ADDR_W-1:0]             i_addr,
    output logic [31:0]                   o_instr,
    output logic                          o_p_waitrequest,
    output logic                          m_read,
    output logic [ADDR_W-1:0]             m_address,
    output logic [$clog2(LINE_WORDS):0]   m_burstcount,
    input  logic                          m_waitrequest,
    input  logic [31:0]                   m_readdata,
    input  logic                          m_readdatavalid
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int BC_W  = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [31:0]       line_r [LINE_WORDS];
    logic [TAG_W-1:0]  tag_r;
    logic              valid_r;
    logic [IDX_W-1:0]  cnt_r;
    logic              m_read_r;
    logic [ADDR_W-1:0] m_address_r;

    logic [IDX_W-1:0]  word_idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic              hit_s;
    logic              start_s;
    logic              accept_s;
    logic              beat_s;
    logic              last_beat_s;
    logic              flush_idle_s;
    logic              kill_fill_s;
    logic              unused_s;

    assign word_idx_s = i_addr[IDX_W+1:2];
    assign tag_s      = i_addr[ADDR_W-1:IDX_W+2];
    assign unused_s   = ^i_addr[1:0];
    assign hit_s      = valid_r && (tag_s == tag_r) && (state_r == ST_IDLE);

    assign o_p_waitrequest = !hit_s;
    assign o_instr         = hit_s ? line_r[word_idx_s] : 32'h0000_0000;
    assign m_read          = m_read_r;
    assign m_address       = m_address_r;
    assign m_burstcount    = BC_W'(LINE_WORDS);

`ifdef IMEM_FLUSH_EN
    logic flush_pend_r;

    assign flush_idle_s = i_flush && (state_r == ST_IDLE);
    // A flush during a refill still lets the burst finish but must not publish the line.
    assign kill_fill_s  = flush_pend_r || i_flush;

    // Pending-flush flag: set while busy, cleared on return to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pend_r <= 1'b0;
        end else if (state_next_s == ST_IDLE) begin
            flush_pend_r <= 1'b0;
        end else if (i_flush && (state_r != ST_IDLE)) begin
            flush_pend_r <= 1'b1;
        end else begin
            flush_pend_r <= flush_pend_r;
        end
    end
`else
    assign flush_idle_s = 1'b0;
    assign kill_fill_s  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and per-edge control strobes.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        accept_s     = 1'b0;
        beat_s       = 1'b0;
        last_beat_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!hit_s) begin
                    state_next_s = ST_REQ;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!m_waitrequest) begin
                    state_next_s = ST_FILL;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_FILL: begin
                if (m_readdatavalid) begin
                    beat_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        last_beat_s  = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Tag, validity, beat counter and burst request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_r       <= '0;
            valid_r     <= 1'b0;
            cnt_r       <= '0;
            m_read_r    <= 1'b0;
            m_address_r <= '0;
        end else begin
            if (start_s) begin
                tag_r       <= tag_s;
                valid_r     <= 1'b0;
                cnt_r       <= '0;
                m_read_r    <= 1'b1;
                m_address_r <= {tag_s, {(IDX_W + 2){1'b0}}};
            end else begin
                if (accept_s) begin
                    m_read_r <= 1'b0;
                end
                if (beat_s) begin
                    cnt_r <= cnt_r + IDX_W'(1);
                end
                if (last_beat_s) begin
                    valid_r <= !kill_fill_s;
                end else if (flush_idle_s) begin
                    valid_r <= 1'b0;
                end
            end
        end
    end

    // Line storage: only beats accepted in FILL write it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_r[i] <= 32'h0000_0000;
            end
        end else if (beat_s) begin
            line_r[cnt_r] <= m_readdata;
        end
    end

endmodule

// File: tb/tb_imem_line_responder.sv
// Self-checking bench for imem_line_responder against a line-buffer reference model.
module tb_imem_line_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] o_instr;
    logic        o_p_waitrequest;
    logic        m_read;
    logic [31:0] m_address;
    logic [2:0]  m_burstcount;
    logic        m_waitrequest = 1'b0;
    logic [31:0] m_readdata = 32'h0;
    logic        m_readdatavalid = 1'b0;
    logic        flush_req = 1'b0;
`ifdef IMEM_FLUSH_EN
    logic        i_flush = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] beat_q [4];
    logic        ref_valid = 1'b0;
    logic [27:0] ref_tag = 28'h0;
    logic [31:0] ref_line [4];

    imem_line_responder #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clk(clk),
        .rst(rst),
`ifdef IMEM_FLUSH_EN
        .i_flush(i_flush),
`endif
        .i_addr(i_addr),
        .o_instr(o_instr),
        .o_p_waitrequest(o_p_waitrequest),
        .m_read(m_read),
        .m_address(m_address),
        .m_burstcount(m_burstcount),
        .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid)
    );

    always #5 clk = ~clk;

    function automatic logic ref_hit(input logic [31:0] a);
        return ref_valid && (a[31:4] == ref_tag);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_line[a[3:2]];
    endfunction

    task automatic ref_commit(input logic [31:0] a);
        ref_tag = a[31:4];
        for (int i = 0; i < 4; i++) ref_line[i] = beat_q[i];
        ref_valid = 1'b1;
    endtask

    task automatic drive(input logic [31:0] a, input logic mw, input logic rdv, input logic [31:0] rd);
        @(negedge clk);
        i_addr = a;
        m_waitrequest = mw;
        m_readdatavalid = rdv;
        m_readdata = rd;
`ifdef IMEM_FLUSH_EN
        i_flush = flush_req;
`endif
        #1;
    endtask

    // Drives the REQ cycles (nwait stalled + one accepting) with junk read strobes.
    task automatic req_phase(input logic [31:0] a, input int nwait, output int mread_n,
                             output logic [31:0] maddr, output int unstable);
        mread_n = 0;
        unstable = 0;
        maddr = 32'h0;
        for (int k = 0; k <= nwait; k++) begin
            drive(a, (k < nwait), 1'($urandom_range(0, 1)), $urandom);
            if (m_read === 1'b1) mread_n++;
            if (m_burstcount !== 3'd4) unstable++;
            if (k == 0) maddr = m_address;
            else if (m_address !== maddr) unstable++;
        end
    endtask

    // Delivers beat_q[0..3] following pattern pat (ones after plen).
    task automatic fill_phase(input logic [31:0] a, input logic [15:0] pat, input int plen,
                              output int early, output int mread_late);
        int b;
        logic v;
        b = 0;
        early = 0;
        mread_late = 0;
        for (int k = 0; k < 64 && b < 4; k++) begin
            v = (k < plen) ? pat[k] : 1'b1;
            drive(a, 1'b0, v, v ? beat_q[b] : $urandom);
            if (o_p_waitrequest !== 1'b1) early++;
            if (m_read !== 1'b0) mread_late++;
            if (v) b++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) drive($urandom, 1'b0, 1'b1, $urandom);
        checks++; if (o_p_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_wait: got %b expected 1", o_p_waitrequest); end
        checks++; if (o_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", o_instr); end
        checks++; if (m_read !== 1'b0) begin failures++; $display("FAIL reset_mread: got %b expected 0", m_read); end
        checks++; if (m_address !== 32'h0) begin failures++; $display("FAIL reset_maddr: got %h expected 0", m_address); end
        checks++; if (m_burstcount !== 3'd4) begin failures++; $display("FAIL reset_burst: got %0d expected 4", m_burstcount); end
        ref_valid = 1'b0;
    endtask

    task automatic test_cold_miss();
        int n, u, early, late;
        logic [31:0] ma;
        beat_q[0] = 32'h11; beat_q[1] = 32'h22; beat_q[2] = 32'h33; beat_q[3] = 32'h44;
        @(negedge clk);
        rst = 1'b1; i_addr = 32'h0; m_waitrequest = 1'b0; m_readdatavalid = 1'b0;
        #1;
        checks++; if (o_p_waitrequest !== 1'b1) begin failures++; $display("FAIL cold_detect_wait: got %b expected 1", o_p_waitrequest); end
        checks++; if (m_read !== 1'b0) begin failures++; $display("FAIL cold_detect_mread: got %b expected 0", m_read); end
        req_phase(32'h0, 0, n, ma, u);
        checks++; if (n !== 1) begin failures++; $display("FAIL cold_mread_cycles: got %0d expected 1", n); end
        checks++; if (ma !== 32'h0) begin failures++; $display("FAIL cold_maddr: got %h expected 0", ma); end
        checks++; if (u !== 0) begin failures++; $display("FAIL cold_req_stable: got %0d expected 0", u); end
        fill_phase(32'h0, 16'hFFFF, 16, early, late);
        checks++; if (early !== 0) begin failures++; $display("FAIL cold_early_hit: got %0d expected 0", early); end
        checks++; if (late !== 0) begin failures++; $display("FAIL cold_mread_late: got %0d expected 0", late); end
        ref_commit(32'h0);
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (o_p_waitrequest !== 1'b0) begin failures++; $display("FAIL cold_hit_wait: got %b expected 0", o_p_waitrequest); end
        checks++; if (o_instr !== 32'h11) begin failures++; $display("FAIL cold_hit_instr: got %h expected 11", o_instr); end
    endtask

    task automatic test_hit();
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            a = (k == 0) ? 32'h8 : 32'hC;
            drive(a, 1'b0, 1'b0, 32'h0);
            checks++; if (o_instr !== ref_word(a)) begin failures++; $display("FAIL hit_instr: got %h expected %h", o_instr, ref_word(a)); end
            checks++; if (o_p_waitrequest !== 1'b0) begin failures++; $display("FAIL hit_wait: got %b expected 0", o_p_waitrequest); end
            checks++; if (m_read !== 1'b0) begin failures++; $display("FAIL hit_mread: got %b expected 0", m_read); end
        end
    endtask

    task automatic test_backpressure();
        int n, u, early, late;
        logic [31:0] ma;
        drive(32'h14, 1'b1, 1'b0, 32'h0);
        checks++; if (o_p_waitrequest !== 1'b1) begin failures++; $display("FAIL bp_detect_wait: got %b expected 1", o_p_waitrequest); end
        ref_valid = 1'b0;
        req_phase(32'h14, 3, n, ma, u);
        checks++; if (n !== 4) begin failures++; $display("FAIL bp_mread_cycles: got %0d expected 4", n); end
        checks++; if (ma !== 32'h10) begin failures++; $display("FAIL bp_maddr: got %h expected 10", ma); end
        checks++; if (u !== 0) begin failures++; $display("FAIL bp_req_stable: got %0d expected 0", u); end
        for (int i = 0; i < 4; i++) beat_q[i] = 32'hA0 + i;
        fill_phase(32'h14, 16'hFFFF, 16, early, late);
        checks++; if (early !== 0 || late !== 0) begin failures++; $display("FAIL bp_fill: got early=%0d late=%0d expected 0/0", early, late); end
        ref_commit(32'h14);
        drive(32'h14, 1'b0, 1'b0, 32'h0);
        checks++; if (o_instr !== 32'hA1 || o_p_waitrequest !== 1'b0) begin failures++; $display("FAIL bp_hit: got %h/%b expected a1/0", o_instr, o_p_waitrequest); end
    endtask

    task automatic test_gapped();
        int n, u, early, late;
        logic [31:0] ma;
        drive(32'h20, 1'b0, 1'b0, 32'h0);
        ref_valid = 1'b0;
        req_phase(32'h20, 0, n, ma, u);
        checks++; if (n !== 1 || ma !== 32'h20) begin failures++; $display("FAIL gap_req: got n=%0d addr=%h expected 1/20", n, ma); end
        for (int i = 0; i < 4; i++) beat_q[i] = $urandom;
        fill_phase(32'h20, 16'h0059, 7, early, late);
        checks++; if (early !== 0) begin failures++; $display("FAIL gap_early_hit: got %0d expected 0", early); end
        ref_commit(32'h20);
        for (int w = 0; w < 4; w++) begin
            drive(32'h20 + 32'(w * 4), 1'b0, 1'b0, 32'h0);
            checks++; if (o_p_waitrequest !== 1'b0 || o_instr !== ref_word(32'h20 + 32'(w * 4))) begin
                failures++; $display("FAIL gap_word%0d: got %h/%b expected %h/0", w, o_instr, o_p_waitrequest, ref_word(32'h20 + 32'(w * 4)));
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        int n, u, early, late;
        logic [31:0] ma;
        for (int i = 0; i < 4; i++) beat_q[i] = $urandom;
        drive(32'h10, 1'b0, 1'b0, 32'h0);
        ref_valid = 1'b0;
        req_phase(32'h10, 0, n, ma, u);
        drive(32'h10, 1'b0, 1'b1, beat_q[0]);
        drive(32'h10, 1'b0, 1'b1, beat_q[1]);
        @(negedge clk);
        rst = 1'b0; m_readdatavalid = 1'b0;
        #1;
        checks++; if (m_read !== 1'b0) begin failures++; $display("FAIL rstmid_mread: got %b expected 0", m_read); end
        checks++; if (o_p_waitrequest !== 1'b1) begin failures++; $display("FAIL rstmid_wait: got %b expected 1", o_p_waitrequest); end
        drive(32'h10, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b1; i_addr = 32'h10;
        #1;
        checks++; if (o_p_waitrequest !== 1'b1 || m_read !== 1'b0) begin failures++; $display("FAIL rstmid_detect: got wait=%b mread=%b expected 1/0", o_p_waitrequest, m_read); end
        req_phase(32'h10, 1, n, ma, u);
        checks++; if (n !== 2 || ma !== 32'h10 || u !== 0) begin failures++; $display("FAIL rstmid_reburst: got n=%0d addr=%h u=%0d expected 2/10/0", n, ma, u); end
        fill_phase(32'h10, 16'h0, 0, early, late);
        ref_commit(32'h10);
        drive(32'h18, 1'b0, 1'b0, 32'h0);
        checks++; if (o_instr !== ref_word(32'h18) || o_p_waitrequest !== 1'b0) begin failures++; $display("FAIL rstmid_hit: got %h expected %h", o_instr, ref_word(32'h18)); end
    endtask

    task automatic test_redirect();
        int n, u, early, late;
        logic [31:0] ma;
        drive(32'h40, 1'b0, 1'b0, 32'h0);
        ref_valid = 1'b0;
        req_phase(32'h40, 0, n, ma, u);
        for (int i = 0; i < 4; i++) beat_q[i] = $urandom;
        fill_phase(32'h100, 16'($urandom), 16, early, late);
        ref_commit(32'h40);
        drive(32'h100, 1'b0, 1'b0, 32'h0);
        checks++; if (o_p_waitrequest !== 1'b1 || m_read !== 1'b0) begin failures++; $display("FAIL redir_remiss: got wait=%b mread=%b expected 1/0", o_p_waitrequest, m_read); end
        ref_valid = 1'b0;
        req_phase(32'h100, 0, n, ma, u);
        checks++; if (n !== 1 || ma !== 32'h100) begin failures++; $display("FAIL redir_reburst: got n=%0d addr=%h expected 1/100", n, ma); end
        for (int i = 0; i < 4; i++) beat_q[i] = $urandom;
        fill_phase(32'h100, 16'h0, 0, early, late);
        ref_commit(32'h100);
    endtask

    task automatic test_random();
        int n, u, early, late, nwait;
        logic [31:0] ma, a, base;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 4))
                0: base = 32'h0000_0000;
                1: base = 32'h0000_0040;
                2: base = 32'h0000_1000;
                3: base = 32'hFFFF_FFF0;
                default: base = $urandom & 32'hFFFF_FFF0;
            endcase
            a = base | ($urandom & 32'hF);
            if (ref_hit(a)) begin
                drive(a, 1'b0, 1'b1, $urandom);
                checks++; if (o_p_waitrequest !== 1'b0 || o_instr !== ref_word(a) || m_read !== 1'b0) begin
                    failures++; $display("FAIL rnd_hit %h: got %h/%b/%b expected %h/0/0", a, o_instr, o_p_waitrequest, m_read, ref_word(a));
                end
            end else begin
                drive(a, 1'b0, 1'b1, $urandom);
                checks++; if (o_p_waitrequest !== 1'b1 || m_read !== 1'b0) begin failures++; $display("FAIL rnd_detect %h: got wait=%b mread=%b expected 1/0", a, o_p_waitrequest, m_read); end
                ref_valid = 1'b0;
                nwait = $urandom_range(0, 3);
                req_phase(a, nwait, n, ma, u);
                checks++; if (n !== nwait + 1 || ma !== {a[31:4], 4'h0} || u !== 0) begin
                    failures++; $display("FAIL rnd_req %h: got n=%0d addr=%h u=%0d expected %0d/%h/0", a, n, ma, u, nwait + 1, {a[31:4], 4'h0});
                end
                for (int i = 0; i < 4; i++) beat_q[i] = $urandom;
                fill_phase(a, 16'($urandom), 16, early, late);
                checks++; if (early !== 0 || late !== 0) begin failures++; $display("FAIL rnd_fill %h: got early=%0d late=%0d expected 0/0", a, early, late); end
                ref_commit(a);
            end
        end
    endtask

`ifdef IMEM_FLUSH_EN
    task automatic test_flush();
        int n, u, early, late;
        logic [31:0] ma;
        drive(32'h200, 1'b0, 1'b0, 32'h0);
        ref_valid = 1'b0;
        req_phase(32'h200, 0, n, ma, u);
        for (int i = 0; i < 4; i++) beat_q[i] = $urandom;
        flush_req = 1'b1;
        drive(32'h200, 1'b0, 1'b1, beat_q[0]);
        flush_req = 1'b0;
        for (int i = 1; i < 4; i++) drive(32'h200, 1'b0, 1'b1, beat_q[i]);
        drive(32'h200, 1'b0, 1'b0, 32'h0);
        checks++; if (o_p_waitrequest !== 1'b1) begin failures++; $display("FAIL flush_fill_wait: got %b expected 1", o_p_waitrequest); end
        req_phase(32'h200, 0, n, ma, u);
        checks++; if (n !== 1 || ma !== 32'h200) begin failures++; $display("FAIL flush_reburst: got n=%0d addr=%h expected 1/200", n, ma); end
        fill_phase(32'h200, 16'h0, 0, early, late);
        ref_commit(32'h200);
        flush_req = 1'b1;
        drive(32'h204, 1'b0, 1'b0, 32'h0);
        flush_req = 1'b0;
        checks++; if (o_p_waitrequest !== 1'b0 || o_instr !== ref_word(32'h204)) begin failures++; $display("FAIL flush_idle_hit: got %h/%b expected %h/0", o_instr, o_p_waitrequest, ref_word(32'h204)); end
        drive(32'h204, 1'b0, 1'b0, 32'h0);
        checks++; if (o_p_waitrequest !== 1'b1) begin failures++; $display("FAIL flush_idle_miss: got %b expected 1", o_p_waitrequest); end
        ref_valid = 1'b0;
        req_phase(32'h204, 0, n, ma, u);
        fill_phase(32'h204, 16'h0, 0, early, late);
        ref_commit(32'h204);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_backpressure();
        test_gapped();
        test_reset_mid_fill();
        test_redirect();
        test_random();
`ifdef IMEM_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
